// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: EX hazards and memory/mul-div handshakes in, per-stage controls out.
// master is the sequencer (pipe_ctrl); slave is the pipeline/stage side.
interface pipe_ctrl_if;
  logic        ex_stall;
  logic        ex_flush;
  logic [31:0] ex_correctpc;
  logic        md_start;
  logic        md_done;
  logic        mem_req;
  logic        dmem_ready;
  logic        imem_ready;
  logic        pc_we;
  logic        if_id_we;
  logic        id_ex_we;
  logic        ex_mem_we;
  logic        mem_wb_we;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_bubble;
  logic        pc_sel;
  logic [31:0] pc_redirect;
  logic        md_go;
  logic        err;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;

  modport master (
    input  ex_stall, ex_flush, ex_correctpc, md_start, md_done, mem_req, dmem_ready, imem_ready,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush,
           ex_mem_bubble, pc_sel, pc_redirect, md_go, err, perf_stall, perf_flush
  );

  modport slave (
    output ex_stall, ex_flush, ex_correctpc, md_start, md_done, mem_req, dmem_ready, imem_ready,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush,
           ex_mem_bubble, pc_sel, pc_redirect, md_go, err, perf_stall, perf_flush
  );
endinterface

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline sequencer: zero-latency combinational stage controls from FSM state + hazards.
// Memory not-ready freezes every stage and overrides all other conditions.
module pipe_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int LD_MAX     = 2
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.master bus
);
  typedef enum logic [2:0] {RUN, LDSTALL, MDWAIT, MEMWAIT, REDIRECT} state_t;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_bubble;
    logic pc_sel;
    logic md_go;
  } ctl_t;

  localparam ctl_t ALL_WE = 10'b11111_00000;
  localparam ctl_t FREEZE = 10'b00001_00100;

  state_t      state_q, state_d, run_state;
  ctl_t        ctl, run_ctl;
  logic [31:0] redirect, redir_q, perf_stall_q, perf_flush_q;
  logic [1:0]  ld_cnt_q, ld_cnt_d;
  logic [6:0]  md_cnt_q, md_cnt_d;
  logic        md_done_q, md_done_d, err_q;
  logic        run_flush, run_redir_load, use_run, set_err, hold;
  logic        flush_inc, redir_load;

  assign hold = bus.mem_req & ~bus.dmem_ready;

  // RUN priority decode, also reused by states that fall back to RUN in the same cycle
  always_comb begin
    run_ctl        = '0;
    run_state      = RUN;
    run_flush      = 1'b0;
    run_redir_load = 1'b0;
    if (hold) begin
      run_state = MEMWAIT;
    end else if (bus.ex_stall) begin
      run_ctl   = FREEZE;
      run_state = LDSTALL;
    end else if (bus.md_start) begin
      run_ctl       = FREEZE;
      run_ctl.md_go = 1'b1;
      run_state     = MDWAIT;
    end else if (bus.ex_flush) begin
      run_ctl             = ALL_WE;
      run_ctl.pc_sel      = 1'b1;
      run_ctl.if_id_flush = 1'b1;
      run_ctl.id_ex_flush = 1'b1;
      run_flush           = 1'b1;
      if (!bus.imem_ready) begin
        run_state      = REDIRECT;
        run_redir_load = 1'b1;
      end
    end else if (!bus.imem_ready) begin
      run_ctl             = ALL_WE;
      run_ctl.pc_we       = 1'b0;
      run_ctl.if_id_flush = 1'b1;
    end else begin
      run_ctl = ALL_WE;
    end
  end

  always_comb begin
    ctl       = '0;
    redirect  = '0;
    state_d   = state_q;
    use_run   = 1'b0;
    set_err   = 1'b0;
    ld_cnt_d  = '0;
    md_cnt_d  = '0;
    md_done_d = 1'b0;
    case (state_q)
      RUN: use_run = 1'b1;
      LDSTALL: begin
        if (bus.ex_stall) begin
          ctl      = FREEZE;
          ld_cnt_d = (ld_cnt_q == 2'd3) ? ld_cnt_q : ld_cnt_q + 2'd1;
          set_err  = (int'(ld_cnt_q) >= LD_MAX);
        end else begin
          use_run = 1'b1;
        end
      end
      MDWAIT: begin
        ctl = FREEZE;
        if (hold) begin
          // a done pulse seen under a memory hold is kept until the hold lifts
          ctl       = '0;
          md_cnt_d  = md_cnt_q;
          md_done_d = md_done_q | bus.md_done;
        end else if (bus.md_done || md_done_q) begin
          ctl.ex_mem_we     = 1'b1;
          ctl.ex_mem_bubble = 1'b0;
          state_d           = RUN;
        end else if (md_cnt_q == 7'(MD_TIMEOUT - 1)) begin
          set_err = 1'b1;
          state_d = RUN;
        end else begin
          md_cnt_d = md_cnt_q + 7'd1;
        end
      end
      MEMWAIT: use_run = bus.dmem_ready;
      REDIRECT: begin
        if (!hold) begin
          ctl             = ALL_WE;
          ctl.if_id_flush = 1'b1;
          if (bus.imem_ready) state_d = RUN;
        end
        ctl.pc_sel = 1'b1;
        redirect   = redir_q;
      end
      default: state_d = RUN;
    endcase
    if (use_run) begin
      ctl      = run_ctl;
      redirect = run_ctl.pc_sel ? bus.ex_correctpc : '0;
      state_d  = run_state;
    end
    if (rst) begin
      ctl      = '0;
      redirect = '0;
    end
  end

  assign flush_inc  = use_run & run_flush;
  assign redir_load = use_run & run_redir_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      ld_cnt_q     <= '0;
      md_cnt_q     <= '0;
      md_done_q    <= 1'b0;
      redir_q      <= '0;
      err_q        <= 1'b0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      md_cnt_q  <= md_cnt_d;
      md_done_q <= md_done_d;
      if (redir_load) redir_q <= bus.ex_correctpc;
      if (set_err) err_q <= 1'b1;
      if (!ctl.pc_we) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush_inc) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign bus.pc_we         = ctl.pc_we;
  assign bus.if_id_we      = ctl.if_id_we;
  assign bus.id_ex_we      = ctl.id_ex_we;
  assign bus.ex_mem_we     = ctl.ex_mem_we;
  assign bus.mem_wb_we     = ctl.mem_wb_we;
  assign bus.if_id_flush   = ctl.if_id_flush;
  assign bus.id_ex_flush   = ctl.id_ex_flush;
  assign bus.ex_mem_bubble = ctl.ex_mem_bubble;
  assign bus.pc_sel        = ctl.pc_sel;
  assign bus.md_go         = ctl.md_go;
  assign bus.pc_redirect   = redirect;
  assign bus.err           = err_q;
  assign bus.perf_stall    = perf_stall_q;
  assign bus.perf_flush    = perf_flush_q;
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencer for the 5-stage RV32I core. It turns the EX-stage hazard outputs (forwarding stall, branch/jump flush with corrected PC) and the memory and multi-cycle-unit handshakes into per-stage write enables, bubble/flush controls and PC redirect signals. It sits beside the pipeline registers and is the only block allowed to freeze or flush them.

## Interface
- `MD_TIMEOUT`, default 64: maximum number of MDWAIT cycles before `err` is raised.
- `LD_MAX`, default 2: maximum number of consecutive LDSTALL cycles before `err` is raised.
- `clk` in 1: clock; every register updates on the rising edge.
- `rst` in 1: reset. It is synchronous and active-high.
- `ex_stall` in 1: load-use stall from the EX forwarding logic.
- `ex_flush` in 1: the EX branch/jump target differs from the fetched next PC.
- `ex_correctpc` in 32: redirect target, valid when `ex_flush`=1.
- `md_start` in 1: the EX instruction needs the multi-cycle mul/div unit.
- `md_done` in 1: mul/div result valid, 1-cycle pulse.
- `mem_req` in 1: the MEM stage holds a valid load or store.
- `dmem_ready` in 1: data memory accepts or returns data this cycle.
- `imem_ready` in 1: instruction memory returns a word this cycle.
- `pc_we`, `if_id_we`, `id_ex_we`, `ex_mem_we`, `mem_wb_we` out 1 each: per-register write enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_bubble` out 1 each: load a NOP into that register on the next edge.
- `pc_sel` out 1: when 1, the PC loads `pc_redirect` instead of PC+4.
- `pc_redirect` out 32: redirect target.
- `md_go` out 1: 1-cycle start pulse to the mul/div unit.
- `err` out 1: sticky protocol-error flag, cleared only by `rst`.
- `perf_stall` out 32: count of cycles with `pc_we`=0.
- `perf_flush` out 32: count of accepted redirects.

## Operation
- FSM states: RUN, LDSTALL, MDWAIT, MEMWAIT, REDIRECT. Reset state is RUN.
- RUN evaluates conditions in priority order; the first match wins:
  1. `mem_req & !dmem_ready`: all five `_we`=0, go to MEMWAIT.
  2. `ex_stall`: `pc_we`, `if_id_we`, `id_ex_we`=0; `ex_mem_bubble`=1; `mem_wb_we`=1; go to LDSTALL.
  3. `md_start`: `md_go`=1; freeze as in LDSTALL; go to MDWAIT.
  4. `ex_flush`: all `_we`=1, `pc_sel`=1, `pc_redirect`=`ex_correctpc`, `if_id_flush`=`id_ex_flush`=1, `perf_flush`+1. If `imem_ready`=0, latch the target into `redir_q` and go to REDIRECT; otherwise stay in RUN.
  5. `!imem_ready`: `pc_we`=0, `if_id_flush`=1, all other `_we`=1.
  6. Otherwise: all `_we`=1, no flush.
- `ex_flush` is ignored while `ex_stall` or `md_start` is asserted, because the branch operands are not yet valid. It is re-evaluated when the FSM returns to RUN.
- LDSTALL:
  - Outputs as in RUN step 2 while `ex_stall`=1. A 2-bit counter increments each cycle; if the count exceeds `LD_MAX`, set `err` and stay in LDSTALL.
  - Return to RUN on the first cycle with `ex_stall`=0. That cycle is decoded as RUN in the same cycle, with no lost cycle.
- MDWAIT:
  - Freeze as in LDSTALL; `md_go`=0.
  - On `md_done`: `ex_mem_we`=1 (no bubble) to capture the result, then return to RUN.
  - A 7-bit counter runs in this state; when it reaches `MD_TIMEOUT`, set `err`, force a return to RUN and bubble EX/MEM.
- MEMWAIT: all `_we`=0 until `dmem_ready`=1, then return to RUN. That cycle is decoded as RUN.
- REDIRECT:
  - `pc_sel`=1, `pc_redirect`=`redir_q`, `pc_we`=1, `if_id_flush`=1, all other `_we`=1, no double count in `perf_flush`.
  - Stay until `imem_ready`=1, then return to RUN.
  - A `mem_req & !dmem_ready` stall takes priority: all `_we`=0 and REDIRECT is held, with `redir_q` kept.
- Perf counters are 32-bit, wrap modulo 2^32, and update only outside reset.

## Timing
- During and after `rst`: state RUN, all counters 0, `redir_q`=0, `err`=0.
  - The registered reset value of every output is 0.
  - The combinational decode is masked to 0 while `rst`=1: all `_we`, flush, `pc_sel`, `md_go`=0 and `pc_redirect`=0.
- All control outputs are combinational from state plus inputs, with zero latency: the redirect takes effect on the same edge that `ex_flush` is seen.
- `md_go` is high for exactly one cycle per mul/div instruction. Re-entry is impossible until MDWAIT exits.
- Simultaneous `md_done` and `mem_req & !dmem_ready`: the memory hold wins and the FSM stays in MDWAIT. The `md_done` pulse is latched into `md_done_q` and consumed on the next non-held cycle.
- Asserting `rst` mid-MDWAIT or mid-REDIRECT aborts the operation. There are no pending pulses after release.

## Test plan
- Load-use: `ex_stall`=1 for 1 cycle → `pc_we`=0, `ex_mem_bubble`=1 for that cycle only; `perf_stall`=1; `err`=0.
- Taken branch: `ex_flush`=1, `ex_correctpc`=0x0000_0120, `imem_ready`=1 → same cycle `pc_sel`=1, `pc_redirect`=0x120, both flushes=1; `perf_flush`=1.
- Redirect with fetch busy: `ex_flush` plus `imem_ready`=0 for 3 cycles → `pc_sel`=1 and `pc_redirect`=0x120 held for 4 cycles; `perf_flush`=1.
- Mul/div: `md_start` → `md_go` is a 1-cycle pulse; freeze for 5 cycles; `md_done` → `ex_mem_we`=1; RUN next cycle. With no `md_done` for 64 cycles → `err`=1.
- Memory hold during MDWAIT with `md_done` coincident → all `_we`=0; `md_done` is consumed on the first cycle with `dmem_ready`=1.
- Priority: `ex_stall`=1 and `ex_flush`=1 together → no redirect (`pc_sel`=0); redirect happens on the first cycle with `ex_stall`=0.
